// File: rtl/uart_tx_arbiter_if.sv
// Producer/serializer handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment (producers plus uart_tx).

interface uart_tx_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_tbus;
   logic              tx_start;
   logic              tx_ready;
   logic [IDW-1:0]    grant_id;
   logic              busy;

   modport slave (
      input  req_valid, req_data, tx_ready,
      output req_ready, tx_tbus, tx_start, grant_id, busy
   );

   modport master (
      output req_valid, req_data, tx_ready,
      input  req_ready, tx_tbus, tx_start, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NREQ byte producers, one byte per frame.
// Round-robin by default; define UART_ARB_FIXED_PRIORITY_EN for lowest-index-wins.

// state    | meaning
// ST_IDLE  | waiting for uart_tx ready and any request; accepts the winner
// ST_START | one-cycle start pulse to uart_tx with the held byte
// ST_BUSY  | frame on the line; leave on the end-of-frame ready pulse
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arbiter_if.slave   bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if ((2 ** IDW) < NREQ) begin : g_bad_idw
      $error("uart_tx_arbiter: IDW too narrow for NREQ");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      data_q, data_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;
   logic            busy_q, busy_d;

   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] win_oh;
   logic [IDW-1:0]  win_idx;
   logic [7:0]      win_byte;
   logic            accept;

`ifdef UART_ARB_FIXED_PRIORITY_EN
   always_comb begin
      cand = bus.req_valid;
   end
`else
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] hi_mask;
   logic [NREQ-1:0] masked;

   // Requests at or above ptr win first; otherwise wrap to the lowest request.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         hi_mask[i] = (i >= int'(ptr_q));
      end
      masked = bus.req_valid & hi_mask;
      cand   = (|masked) ? masked : bus.req_valid;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         if (int'(win_idx) == NREQ - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = PW'(int'(win_idx) + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_idx   = IDW'(i);
         end
      end
   end

   always_comb begin
      win_byte = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_byte = bus.req_data[8*i +: 8];
         end
      end
   end

   assign accept = (state_q == ST_IDLE) && bus.tx_ready && (|bus.req_valid);

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      grant_id_d = grant_id_q;
      busy_d     = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_START;
               data_d     = win_byte;
               grant_id_d = win_idx;
               busy_d     = 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (bus.tx_ready) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         data_q     <= 8'h00;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
      end
   end

   // rst_n gates the accept so producers never see a transfer during reset.
   assign bus.req_ready = (accept && rst_n) ? win_oh : '0;
   assign bus.tx_start  = (state_q == ST_START);
   assign bus.tx_tbus   = data_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.busy      = busy_q;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.req_ready));
   a_start_single: assert property (@(posedge clk) disable iff (!rst_n)
      bus.tx_start |=> !bus.tx_start);

endmodule
